fp_normalizer: RTL and testbench

Post-add stage of the FP adder datapath. It is the counterpart of the unpack/align front end. It takes the raw signed-magnitude mantissa sum and the shared alignment exponent, normalizes the sum iteratively, and repacks the result into an IEEE-754 single-precision word. It sits after the mantissa adder and uses a valid/ready handshake on both sides.

---
 rtl/fp_normalizer.sv | 187 ++++++++++++++++++
 tb/tb_fp_normalizer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// fp_normalizer: post-add normalize and repack stage of the FP adder.
// It takes the signed-magnitude mantissa sum and the shared alignment exponent,
// normalizes the sum, and packs an IEEE-754 style {sign, exponent, fraction} word.
// Truncation only; there is no rounding.
// Optional macro FP_NORM_FAST_EN: when defined, the left-normalize step uses a
// leading-zero count and finishes in one cycle instead of one bit per cycle.
module fp_normalizer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     sign_in,
  input  logic [EXP_W-1:0]         exponent_in,
  input  logic [MAN_W+1:0]         mantissa_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     overflow,
  output logic                     underflow
);

  typedef enum logic [1:0] {IDLE, EVAL, SHIFT, DONE} state_t;

  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [EXP_W-1:0] EXP_ZERO  = '0;
  localparam logic [MAN_W-1:0] FRAC_ZERO = '0;

  state_t                 state_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [EXP_W+MAN_W:0]   result_q;
  logic                   ovf_q;
  logic                   unf_q;
  logic                   sign_q;
  logic [EXP_W-1:0]       exp_q;
  logic [MAN_W+1:0]       mant_q;

  logic [EXP_W-1:0]       expInc_d;
  logic [EXP_W-1:0]       expDec_d;

  // Exponent neighbours used by the carry and shift paths; wrap-around is
  // prevented by the all-ones and zero checks that guard their use.
  always_comb begin
    expInc_d = exp_q + EXP_W'(1);
    expDec_d = exp_q - EXP_W'(1);
  end

`ifdef FP_NORM_FAST_EN
  localparam int LZW = $clog2(MAN_W + 2);
  localparam int CW  = (EXP_W > LZW) ? EXP_W : LZW;

  // Count leading zeros from the hidden-bit position downwards.
  function automatic logic [CW-1:0] countLz(input logic [MAN_W:0] m);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = MAN_W; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n     = n + CW'(1);
      end
    end
    return n;
  endfunction

  logic [CW-1:0]    lzc_d;
  logic             shiftUnf_d;
  logic [MAN_W+1:0] shiftMant_d;
  logic [EXP_W-1:0] shiftExp_d;

  // One-shot normalization: if the exponent cannot absorb the whole shift,
  // the one-bit-per-cycle walk would hit exp==0 first, so flush instead.
  always_comb begin
    lzc_d       = countLz(mant_q[MAN_W:0]);
    shiftUnf_d  = (lzc_d >= CW'(exp_q));
    shiftMant_d = mant_q << lzc_d;
    shiftExp_d  = exp_q - EXP_W'(lzc_d);
  end
`endif

  // Control FSM with registered handshake, result and flag outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            sign_q     <= sign_in;
            exp_q      <= exponent_in;
            mant_q     <= mantissa_in;
            in_ready_q <= 1'b0;
            state_q    <= EVAL;
          end
        end

        EVAL: begin
          if (exp_q == EXP_MAX) begin
            result_q <= {sign_q, EXP_MAX, FRAC_ZERO};
            ovf_q    <= 1'b1;
            state_q  <= DONE;
          end else if (mant_q == '0) begin
            result_q <= {sign_q, EXP_ZERO, FRAC_ZERO};
            state_q  <= DONE;
          end else if (mant_q[MAN_W+1]) begin
            if (expInc_d == EXP_MAX) begin
              result_q <= {sign_q, EXP_MAX, FRAC_ZERO};
              ovf_q    <= 1'b1;
            end else begin
              result_q <= {sign_q, expInc_d, mant_q[MAN_W:1]};
            end
            state_q <= DONE;
          end else if (exp_q == EXP_ZERO) begin
            result_q <= {sign_q, EXP_ZERO, FRAC_ZERO};
            unf_q    <= 1'b1;
            state_q  <= DONE;
          end else if (mant_q[MAN_W]) begin
            result_q <= {sign_q, exp_q, mant_q[MAN_W-1:0]};
            state_q  <= DONE;
          end else begin
            state_q <= SHIFT;
          end
        end

        SHIFT: begin
`ifdef FP_NORM_FAST_EN
          if (shiftUnf_d) begin
            result_q <= {sign_q, EXP_ZERO, FRAC_ZERO};
            unf_q    <= 1'b1;
          end else begin
            result_q <= {sign_q, shiftExp_d, shiftMant_d[MAN_W-1:0]};
          end
          state_q <= DONE;
`else
          if (exp_q == EXP_ZERO) begin
            result_q <= {sign_q, EXP_ZERO, FRAC_ZERO};
            unf_q    <= 1'b1;
            state_q  <= DONE;
          end else if (mant_q[MAN_W]) begin
            result_q <= {sign_q, exp_q, mant_q[MAN_W-1:0]};
            state_q  <= DONE;
          end else begin
            mant_q <= mant_q << 1;
            exp_q  <= expDec_d;
          end
`endif
        end

        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed self-checking bench for fp_normalizer (EXP_W=8, MAN_W=23).
// Expected latencies follow FP_NORM_FAST_EN when the bench is built with it.
module tb_fp_normalizer;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic                 sign_in;
  logic [EXP_W-1:0]     exponent_in;
  logic [MAN_W+1:0]     mantissa_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [EXP_W+MAN_W:0] result;
  logic                 overflow;
  logic                 underflow;

  int testsRun    = 0;
  int testsFailed = 0;

  fp_normalizer #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign_in    (sign_in),
    .exponent_in(exponent_in),
    .mantissa_in(mantissa_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Present one sum; returns 1 ns after the accept edge T.
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [24:0] m);
    @(negedge clk);
    sign_in     = s;
    exponent_in = e;
    mantissa_in = m;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Returns n if out_valid is first seen after edge T+n, or -1 on timeout.
  task automatic waitValid(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic completeHandshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign_in   = 1'b0;
    exponent_in = '0;
    mantissa_in = '0;
    repeat (2) @(posedge clk);
    #1;
    testsRun++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset handshake: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    testsRun++;
    if (result !== 32'h0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset outputs: got result=%h ovf=%b unf=%b expected 0 0 0", result, overflow, underflow);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Sums resolved in the single EVAL cycle: out_valid at T+2.
  task automatic test_eval_paths();
    logic        vS   [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0]  vE   [8] = '{8'h80, 8'h40, 8'hFE, 8'hFF, 8'h00, 8'h85, 8'h80, 8'hFF};
    logic [24:0] vM   [8] = '{25'h1800000, 25'h0000000, 25'h1000000, 25'h0800000,
                              25'h0400000, 25'h0C00000, 25'h1800001, 25'h0000000};
    logic [31:0] vRes [8] = '{32'h40C00000, 32'h80000000, 32'h7F800000, 32'h7F800000,
                              32'h00000000, 32'hC2C00000, 32'h40C00000, 32'hFF800000};
    logic        vOvf [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        vUnf [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vS[i], vE[i], vM[i]);
      waitValid(lat);
      testsRun++;
      if (lat !== 2) begin
        testsFailed++;
        $display("[TB] FAIL eval[%0d] latency: got T+%0d expected T+2", i, lat);
      end
      testsRun++;
      if (result !== vRes[i] || overflow !== vOvf[i] || underflow !== vUnf[i]) begin
        testsFailed++;
        $display("[TB] FAIL eval[%0d] result: got %h ovf=%b unf=%b expected %h ovf=%b unf=%b",
                 i, result, overflow, underflow, vRes[i], vOvf[i], vUnf[i]);
      end
      testsRun++;
      if (in_ready !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL eval[%0d] in_ready in DONE: got %b expected 0", i, in_ready);
      end
      completeHandshake();
    end
  endtask

  // Sums that need left normalization, including underflow boundaries.
  task automatic test_left_shift();
    logic [7:0]  vE    [5] = '{8'h80, 8'h02, 8'h80, 8'h17, 8'h18};
    logic [24:0] vM    [5] = '{25'h0200000, 25'h0000001, 25'h0000001, 25'h0000001, 25'h0000001};
    logic [31:0] vRes  [5] = '{32'h3F000000, 32'h00000000, 32'h34800000, 32'h00000000, 32'h00800000};
    logic        vUnf  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef FP_NORM_FAST_EN
    int          vLat  [5] = '{3, 3, 3, 3, 3};
`else
    int          vLat  [5] = '{5, 5, 26, 26, 26};
`endif
    int lat;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, vE[i], vM[i]);
      waitValid(lat);
      testsRun++;
      if (lat !== vLat[i]) begin
        testsFailed++;
        $display("[TB] FAIL shift[%0d] latency: got T+%0d expected T+%0d", i, lat, vLat[i]);
      end
      testsRun++;
      if (result !== vRes[i] || overflow !== 1'b0 || underflow !== vUnf[i]) begin
        testsFailed++;
        $display("[TB] FAIL shift[%0d] result: got %h ovf=%b unf=%b expected %h ovf=0 unf=%b",
                 i, result, overflow, underflow, vRes[i], vUnf[i]);
      end
      completeHandshake();
      testsRun++;
      if (out_valid !== 1'b0 || underflow !== 1'b0 || in_ready !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL shift[%0d] after handshake: got out_valid=%b unf=%b in_ready=%b expected 0 0 1",
                 i, out_valid, underflow, in_ready);
      end
    end
  endtask

  // Held result under backpressure; a waiting sum is taken only after release.
  task automatic test_back_to_back();
    int lat;
    applyStimulus(1'b0, 8'hFE, 25'h1000000);
    waitValid(lat);
    testsRun++;
    if (lat !== 2 || overflow !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL bp first: got T+%0d ovf=%b expected T+2 ovf=1", lat, overflow);
    end
    @(negedge clk);
    sign_in     = 1'b1;
    exponent_in = 8'h85;
    mantissa_in = 25'h0C00000;
    in_valid    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      testsRun++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h7F800000 ||
          overflow !== 1'b1 || underflow !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL bp hold[%0d]: got valid=%b rdy=%b res=%h ovf=%b unf=%b expected 1 0 7f800000 1 0",
                 c, out_valid, in_ready, result, overflow, underflow);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    testsRun++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bp release: got valid=%b rdy=%b ovf=%b expected 0 1 0", out_valid, in_ready, overflow);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    testsRun++;
    if (in_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bp accept: got in_ready=%b expected 0", in_ready);
    end
    waitValid(lat);
    testsRun++;
    if (lat !== 2 || result !== 32'hC2C00000 || overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bp second: got T+%0d res=%h ovf=%b expected T+2 c2c00000 0", lat, result, overflow);
    end
    completeHandshake();
  endtask

  // Reset while a long normalization is in SHIFT discards it.
  task automatic test_reset_in_shift();
    applyStimulus(1'b0, 8'h80, 25'h0000100);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    testsRun++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 ||
        overflow !== 1'b0 || underflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset in shift: got rdy=%b valid=%b res=%h ovf=%b unf=%b expected 1 0 0 0 0",
               in_ready, out_valid, result, overflow, underflow);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    testsRun++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset idle: got valid=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_eval_paths();
    test_left_shift();
    test_back_to_back();
    // Leave a nonzero result in place so the reset check below is meaningful.
    applyStimulus(1'b0, 8'h80, 25'h1800000);
    begin
      int lat;
      waitValid(lat);
      testsRun++;
      if (lat !== 2 || result !== 32'h40C00000) begin
        testsFailed++;
        $display("[TB] FAIL pre-reset carry: got T+%0d res=%h expected T+2 40c00000", lat, result);
      end
    end
    completeHandshake();
    test_reset_in_shift();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
